// File: rtl/patch_fetch_pkg.sv
// Shared constants, FSM encoding and tag format for the patch fetch path.
package patch_fetch_pkg;

   localparam int DW       = 8;    // pixel width
   localparam int AW       = 10;   // feature-map address width
   localparam int MAP_SIZE = 784;  // addresses at or above this are zero padding
   localparam int NPIX     = 9;    // 3x3 window

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_VALID = 2'd3
   } state_e;

   // One in-flight read: which window slot it fills and whether it is padding.
   typedef struct packed {
      logic       valid;
      logic       zero;
      logic [3:0] idx;
   } rd_tag_t;

   function automatic logic is_pad(input logic [AW-1:0] addr);
      return addr >= AW'(MAP_SIZE);
   endfunction

endpackage

// File: rtl/patch_fetch_if.sv
// Request, BRAM and window-output signals of the patch fetch block.
// Handshakes: start is a one-cycle pulse honoured only while busy=0;
// a window transfers on a clock edge where patch_valid and patch_ready are
// both high, and patch_valid/pix hold steady until that edge.
interface patch_fetch_if;
   import patch_fetch_pkg::*;

   logic          start;
   logic          load_full_patch;
   logic [AW-1:0] pixel_addr [NPIX];
   logic          busy;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          patch_valid;
   logic          patch_ready;
   logic [DW-1:0] pix [NPIX];

   modport slave (
      input  start, load_full_patch, pixel_addr, mem_rdata, patch_ready,
      output busy, mem_rd_en, mem_addr, patch_valid, pix
   );

   modport master (
      output start, load_full_patch, pixel_addr, mem_rdata, patch_ready,
      input  busy, mem_rd_en, mem_addr, patch_valid, pix
   );

endinterface

// File: rtl/patch_fetch_rd_tag_pipe.sv
// Shift register that tracks each BRAM read (or zero-fill) until its data returns.
module patch_fetch_rd_tag_pipe
   import patch_fetch_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o,
   output logic    pending_o  // entries remain behind the output stage
);

   rd_tag_t stage_q [DEPTH];

   // Advance every tag one stage per cycle; reset drops anything in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_o = stage_q[DEPTH-1];

   // The output stage retires this cycle, so only earlier stages keep the pipe busy.
   always_comb begin
      pending_o = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) pending_o = pending_o | stage_q[i].valid;
   end

endmodule

// File: rtl/patch_fetch.sv
// Fetches a 3x3 pixel window from the feature-map BRAM, reusing two columns
// on partial (column-shift) requests, and hands it to the MAC array.
module patch_fetch
   import patch_fetch_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   patch_fetch_if.slave  bus,
   output state_e        dbg_state_o,
   output logic          dbg_have_win_o
);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          partial_q;
   logic          have_win_q;
   logic [AW-1:0] addr_q [NPIX];
   logic [DW-1:0] pix_q [NPIX];
   logic [AW-1:0] last_addr_q;

   logic [3:0]    list_idx;
   logic [3:0]    last_cnt;
   logic [AW-1:0] cur_addr;
   logic          cur_pad;
   logic          accept;
   logic          shift_win;
   rd_tag_t       tag_in, tag_out;
   logic          tag_pending;

   assign accept    = (state_q == ST_IDLE) && bus.start;
   // A partial request only reuses columns when a window already exists.
   assign shift_win = accept && !bus.load_full_patch && have_win_q;

   // Fetch list: all nine slots, or only the right column after a shift.
   always_comb begin
      list_idx = partial_q ? (4'd6 + cnt_q) : cnt_q;
      last_cnt = partial_q ? 4'd2 : 4'd8;
      cur_addr = addr_q[list_idx];
      cur_pad  = is_pad(cur_addr);
   end

   // Next-state logic and the combinational block outputs.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tag_in        = '0;
      bus.mem_rd_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_ISSUE;
               cnt_d   = 4'd0;
            end
         end
         ST_ISSUE: begin
            // Padding takes the issue slot too, so latency never depends on it.
            bus.mem_rd_en = !cur_pad;
            tag_in.valid  = 1'b1;
            tag_in.zero   = cur_pad;
            tag_in.idx    = list_idx;
            cnt_d         = cnt_q + 4'd1;
            if (cnt_q == last_cnt) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!tag_pending) state_d = ST_VALID;
         end
         ST_VALID: begin
            if (bus.patch_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      bus.mem_addr    = bus.mem_rd_en ? cur_addr : last_addr_q;
      bus.busy        = (state_q != ST_IDLE);
      bus.patch_valid = (state_q == ST_VALID);
      for (int i = 0; i < NPIX; i++) bus.pix[i] = pix_q[i];
   end

   assign dbg_state_o    = state_q;
   assign dbg_have_win_o = have_win_q;

   // FSM state and issue counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Latch the request on acceptance; any accepted request leaves a window behind.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         partial_q  <= 1'b0;
         have_win_q <= 1'b0;
         for (int i = 0; i < NPIX; i++) addr_q[i] <= '0;
      end else if (accept) begin
         partial_q  <= shift_win;
         have_win_q <= 1'b1;
         for (int i = 0; i < NPIX; i++) addr_q[i] <= bus.pixel_addr[i];
      end
   end

   // Hold the last real read address so padding slots do not toggle the bus.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)            last_addr_q <= '0;
      else if (bus.mem_rd_en) last_addr_q <= cur_addr;
   end

   // Window register: column shift on a partial accept, otherwise fill from returning reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NPIX; i++) pix_q[i] <= '0;
      end else if (shift_win) begin
         for (int i = 0; i < 6; i++) pix_q[i] <= pix_q[i+3];
      end else if (tag_out.valid) begin
         pix_q[tag_out.idx] <= tag_out.zero ? '0 : bus.mem_rdata;
      end
   end

   patch_fetch_rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tag_i     (tag_in),
      .tag_o     (tag_out),
      .pending_o (tag_pending)
   );

endmodule
